// File: rtl/i2s_dac_tx_pkg.sv
// Shared constants and types for the I2S/left-justified DAC serializer.
package i2s_dac_tx_pkg;

  // Codec defaults: 16-bit samples in 32-BCLK slots, 5-bit delay control.
  localparam int   CODEC_DATA_W = 16;
  localparam int   CODEC_SLOT_W = 32;
  localparam int   CODEC_DLY_W  = 5;

  // DACLRCK level that marks the left channel on this codec.
  localparam logic LRCK_LEFT    = 1'b1;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

endpackage

// File: rtl/i2s_dac_tx_edge_sync.sv
// Two-flop synchroniser for an asynchronous pin, with single-cycle
// rise and fall pulses derived from the synchronised level.
module i2s_dac_tx_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next state: pin through two flops, plus one stage kept for edge detection
  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// Stereo DAC serializer. Oversamples the codec BCLK/DACLRCK on clk_50,
// double-buffers L/R pairs, applies LSB crush and frame-hold rate reduction,
// and shifts MSB-first into AUD_DACDAT through a programmable delay line.
module i2s_dac_tx
  import i2s_dac_tx_pkg::*;
#(
  parameter int   DATA_W   = CODEC_DATA_W,
  parameter int   SLOT_W   = CODEC_SLOT_W,
  parameter int   DLY_W    = CODEC_DLY_W,
  parameter int   I2S_MODE = 0,
  parameter logic LEFT_LVL = LRCK_LEFT
) (
  input  logic              clk_50,
  input  logic              ar,
  input  logic              bclk,
  input  logic              daclrck,
  input  logic              enable,
  input  logic [DATA_W-1:0] din_l,
  input  logic [DATA_W-1:0] din_r,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [4:0]        crush_bits,
  input  logic [3:0]        rate_div,
  input  logic [DLY_W-1:0]  delay,
  output logic              dacdat,
  output logic              frame_strb,
  output logic              underrun
);

  localparam int DLY_D = (2**DLY_W) - 1;
  localparam int PAD_W = SLOT_W - DATA_W;
  localparam int CNT_W = $clog2(SLOT_W + 1);

  // Clear the n lowest bits of a sample; n at or above DATA_W clears all.
  function automatic logic [DATA_W-1:0] crush_word(input logic [DATA_W-1:0] w,
                                                   input logic [4:0]        n);
    int                c;
    logic [DATA_W-1:0] mask;
    c    = (int'(n) > DATA_W) ? DATA_W : int'(n);
    mask = {DATA_W{1'b1}} << c;
    return w & mask;
  endfunction

  // Synchronised codec clocks
  logic bclk_s, bclk_rise_s, bclk_fall_s;
  logic lrck_s, lrck_rise_s, lrck_fall_s;
  logic unused_edges_s;

  i2s_dac_tx_edge_sync u_bclk_sync (
    .clk_i   (clk_50),
    .rst_i   (ar),
    .async_i (bclk),
    .sync_o  (bclk_s),
    .rise_o  (bclk_rise_s),
    .fall_o  (bclk_fall_s)
  );

  i2s_dac_tx_edge_sync u_lrck_sync (
    .clk_i   (clk_50),
    .rst_i   (ar),
    .async_i (daclrck),
    .sync_o  (lrck_s),
    .rise_o  (lrck_rise_s),
    .fall_o  (lrck_fall_s)
  );

  // LRCK is sampled on BCLK falls, so its own edge pulses are not needed here.
  assign unused_edges_s = bclk_s ^ bclk_rise_s ^ lrck_rise_s ^ lrck_fall_s;

  // State
  logic              lrck_prev_q,  lrck_prev_d;
  logic              primed_q,     primed_d;
  logic [SLOT_W-1:0] shreg_q,      shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [DLY_D-1:0]  dly_sr_q,     dly_sr_d;
  logic              dacdat_q,     dacdat_d;
  logic              frame_strb_q, frame_strb_d;
  logic              underrun_q,   underrun_d;
  logic [3:0]        hold_cnt_q,   hold_cnt_d;
  logic [4:0]        crush_q,      crush_d;
  logic [DATA_W-1:0] pend_l_q,     pend_l_d;
  logic [DATA_W-1:0] pend_r_q,     pend_r_d;
  logic              pend_full_q,  pend_full_d;
  logic [DATA_W-1:0] act_l_q,      act_l_d;
  logic [DATA_W-1:0] act_r_q,      act_r_d;

  // Combinational helpers
  logic              accept_s;
  logic              lrck_chg_s;
  logic              left_start_s;
  logic              due_s;
  logic              transfer_s;
  chan_e             chan_s;
  logic [DATA_W-1:0] word_s;
  logic              out_bit_s;
  logic [DLY_W:0]    eff_sum_s;
  logic [DLY_W-1:0]  eff_s;

  // Ready only while the pending buffer is empty and out of reset
  assign din_ready    = ~pend_full_q & ~ar;
  assign accept_s     = din_valid & din_ready;
  // The first fall after reset only records LRCK; framing starts at the next change
  assign lrck_chg_s   = primed_q & (lrck_s != lrck_prev_q);
  assign left_start_s = bclk_fall_s & lrck_chg_s & (lrck_s == LEFT_LVL);
  assign due_s        = left_start_s & enable & (hold_cnt_q == rate_div);
  assign transfer_s   = due_s & pend_full_q;
  assign chan_s       = (lrck_s == LEFT_LVL) ? CH_LEFT : CH_RIGHT;

  // Effective output delay in BCLKs, clamped to the delay-line depth
  always_comb begin
    eff_sum_s = {1'b0, delay} + (DLY_W+1)'(I2S_MODE);
    if (eff_sum_s > (DLY_W+1)'(DLY_D)) begin
      eff_s = DLY_W'(DLY_D);
    end else begin
      eff_s = eff_sum_s[DLY_W-1:0];
    end
  end

  // Buffer handshake, frame hold, slot loading, shifting and delay line
  always_comb begin
    lrck_prev_d  = lrck_prev_q;
    primed_d     = primed_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    dly_sr_d     = dly_sr_q;
    dacdat_d     = dacdat_q;
    frame_strb_d = 1'b0;
    underrun_d   = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    crush_d      = crush_q;
    pend_l_d     = pend_l_q;
    pend_r_d     = pend_r_q;
    pend_full_d  = pend_full_q;
    act_l_d      = act_l_q;
    act_r_d      = act_r_q;
    word_s       = '0;
    out_bit_s    = 1'b0;

    // Pending buffer: a new pair may land while the old one moves to active
    if (accept_s) begin
      pend_l_d    = din_l;
      pend_r_d    = din_r;
      pend_full_d = 1'b1;
    end else if (transfer_s) begin
      pend_full_d = 1'b0;
    end else begin
      pend_full_d = pend_full_q;
    end

    if (transfer_s) begin
      act_l_d = pend_l_q;
      act_r_d = pend_r_q;
    end else begin
      act_l_d = act_l_q;
      act_r_d = act_r_q;
    end

    // Crush depth is frozen for the whole frame at its left-slot start
    if (left_start_s) begin
      frame_strb_d = 1'b1;
      crush_d      = crush_bits;
    end else begin
      frame_strb_d = 1'b0;
      crush_d      = crush_q;
    end

    if (left_start_s && enable) begin
      if (hold_cnt_q == rate_div) begin
        hold_cnt_d = 4'd0;
      end else begin
        hold_cnt_d = hold_cnt_q + 4'd1;
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end

    underrun_d = due_s & ~pend_full_q;

    if (!enable) begin
      word_s = '0;
    end else if (chan_s == CH_LEFT) begin
      word_s = crush_word(act_l_d, crush_d);
    end else begin
      word_s = crush_word(act_r_d, crush_d);
    end

    if (bclk_fall_s) begin
      lrck_prev_d = lrck_s;
      primed_d    = 1'b1;
      if (lrck_chg_s) begin
        shreg_d   = SLOT_W'(word_s) << PAD_W;
        bit_cnt_d = '0;
      end else begin
        shreg_d = shreg_q << 1;
        if (bit_cnt_q < CNT_W'(SLOT_W)) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      // Bits past the end of an over-long slot are silence
      out_bit_s = (bit_cnt_d < CNT_W'(SLOT_W)) ? shreg_d[SLOT_W-1] : 1'b0;
      dly_sr_d  = DLY_D'({dly_sr_q, out_bit_s});
      if (eff_s == '0) begin
        dacdat_d = out_bit_s;
      end else begin
        dacdat_d = dly_sr_q[eff_s - DLY_W'(1)];
      end
    end else begin
      lrck_prev_d = lrck_prev_q;
      primed_d    = primed_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      dly_sr_d    = dly_sr_q;
      dacdat_d    = dacdat_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_50) begin
    if (ar) begin
      lrck_prev_q  <= 1'b0;
      primed_q     <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      dly_sr_q     <= '0;
      dacdat_q     <= 1'b0;
      frame_strb_q <= 1'b0;
      underrun_q   <= 1'b0;
      hold_cnt_q   <= 4'd0;
      crush_q      <= 5'd0;
      pend_l_q     <= '0;
      pend_r_q     <= '0;
      pend_full_q  <= 1'b0;
      act_l_q      <= '0;
      act_r_q      <= '0;
    end else begin
      lrck_prev_q  <= lrck_prev_d;
      primed_q     <= primed_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      dly_sr_q     <= dly_sr_d;
      dacdat_q     <= dacdat_d;
      frame_strb_q <= frame_strb_d;
      underrun_q   <= underrun_d;
      hold_cnt_q   <= hold_cnt_d;
      crush_q      <= crush_d;
      pend_l_q     <= pend_l_d;
      pend_r_q     <= pend_r_d;
      pend_full_q  <= pend_full_d;
      act_l_q      <= act_l_d;
      act_r_q      <= act_r_d;
    end
  end

  assign dacdat     = dacdat_q;
  assign frame_strb = frame_strb_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: a left-justified instance and an I2S instance
// share all inputs; the bench plays codec (BCLK = 8 clk_50, 32 BCLK per slot).
module tb_i2s_dac_tx;

  logic        clk_50 = 1'b0;
  logic        ar, bclk, daclrck, enable, din_valid;
  logic [15:0] din_l, din_r;
  logic [4:0]  crush_bits;
  logic [3:0]  rate_div;
  logic [4:0]  delay;
  logic        din_ready, dacdat, frame_strb, underrun;
  logic        din_ready_i2s, dacdat_i2s, frame_strb_i2s, underrun_i2s;

  int n_checks = 0;
  int n_fail   = 0;
  int strb_cnt = 0, strb_cnt_i2s = 0, urun_cnt = 0, urun_cnt_i2s = 0;
  int exp_strb = 0, exp_urun = 0;

  logic [31:0] lw, rw, lwi, rwi;
  logic        tb_b, tb_bi, acc;

  always #10 clk_50 = ~clk_50;

  i2s_dac_tx #(.I2S_MODE(0)) u_dut (
    .clk_50(clk_50), .ar(ar), .bclk(bclk), .daclrck(daclrck), .enable(enable),
    .din_l(din_l), .din_r(din_r), .din_valid(din_valid), .din_ready(din_ready),
    .crush_bits(crush_bits), .rate_div(rate_div), .delay(delay),
    .dacdat(dacdat), .frame_strb(frame_strb), .underrun(underrun)
  );

  i2s_dac_tx #(.I2S_MODE(1)) u_dut_i2s (
    .clk_50(clk_50), .ar(ar), .bclk(bclk), .daclrck(daclrck), .enable(enable),
    .din_l(din_l), .din_r(din_r), .din_valid(din_valid), .din_ready(din_ready_i2s),
    .crush_bits(crush_bits), .rate_div(rate_div), .delay(delay),
    .dacdat(dacdat_i2s), .frame_strb(frame_strb_i2s), .underrun(underrun_i2s)
  );

  // Count single-cycle output pulses on the inactive edge
  always @(negedge clk_50) begin
    if (frame_strb)     strb_cnt     <= strb_cnt + 1;
    if (frame_strb_i2s) strb_cnt_i2s <= strb_cnt_i2s + 1;
    if (underrun)       urun_cnt     <= urun_cnt + 1;
    if (underrun_i2s)   urun_cnt_i2s <= urun_cnt_i2s + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One BCLK period: fall (with LRCK update), optional pair offered in the
  // cycle the DUT processes this fall, sample dacdat, then BCLK high.
  task automatic do_fall(input logic lr, input logic offer, input logic [15:0] ol,
                         input logic [15:0] orr, output logic b, output logic bi);
    @(negedge clk_50);
    bclk    = 1'b0;
    daclrck = lr;
    @(negedge clk_50);
    @(negedge clk_50);
    if (offer) begin
      din_l     = ol;
      din_r     = orr;
      din_valid = 1'b1;
    end
    @(negedge clk_50);
    din_valid = 1'b0;
    @(negedge clk_50);
    b    = dacdat;
    bi   = dacdat_i2s;
    bclk = 1'b1;
    repeat (3) @(negedge clk_50);
  endtask

  // One full frame: 32 left falls then 32 right falls, captured MSB-first
  task automatic run_frame(input logic offer, input logic [15:0] ol, input logic [15:0] orr);
    logic b, bi;
    for (int k = 0; k < 64; k++) begin
      do_fall(k < 32, offer && (k == 0), ol, orr, b, bi);
      if (k < 32) begin
        lw[31-k]  = b;
        lwi[31-k] = bi;
      end else begin
        rw[63-k]  = b;
        rwi[63-k] = bi;
      end
    end
    exp_strb++;
  endtask

  task automatic offer_pair(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk_50);
    din_l     = l;
    din_r     = r;
    din_valid = 1'b1;
    @(negedge clk_50);
    din_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] el, input logic [31:0] er);
    check_eq({tag, "_left"},  lw, el);
    check_eq({tag, "_right"}, rw, er);
  endtask

  initial begin
    ar = 1'b1; bclk = 1'b1; daclrck = 1'b0; enable = 1'b1; din_valid = 1'b0;
    din_l = 16'h0000; din_r = 16'h0000; crush_bits = 5'd0; rate_div = 4'd0; delay = 5'd0;
    repeat (4) @(negedge clk_50);
    check_eq("rst_dacdat", {31'd0, dacdat}, 32'd0);
    check_eq("rst_frame_strb", {31'd0, frame_strb}, 32'd0);
    check_eq("rst_underrun", {31'd0, underrun}, 32'd0);
    check_eq("rst_ready", {31'd0, din_ready}, 32'd0);
    ar = 1'b0;
    @(negedge clk_50);
    check_eq("ready_after_rst", {31'd0, din_ready}, 32'd1);

    // Prime LRCK tracking inside a right slot
    do_fall(1'b0, 1'b0, 16'h0, 16'h0, tb_b, tb_bi);
    do_fall(1'b0, 1'b0, 16'h0, 16'h0, tb_b, tb_bi);

    // Basic framing, both modes
    offer_pair(16'hA5C3, 16'h0F0F);
    check_eq("ready_full", {31'd0, din_ready}, 32'd0);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("lj_d0", 32'hA5C3_0000, 32'h0F0F_0000);
    check_eq("i2s_d0_left", lwi, 32'h52E1_8000);
    check_eq("i2s_d0_right", rwi, 32'h0787_8000);
    check_eq("ready_after_xfer", {31'd0, din_ready}, 32'd1);

    // One extra BCLK of programmed delay
    delay = 5'd1;
    offer_pair(16'hA5C3, 16'h0F0F);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("lj_d1", 32'h52E1_8000, 32'h0787_8000);
    check_eq("i2s_d1_left", lwi, 32'h2970_C000);
    check_eq("i2s_d1_right", rwi, 32'h03C3_C000);
    delay = 5'd0;

    // Bitcrush
    crush_bits = 5'd4;
    offer_pair(16'h7FFF, 16'h8001);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("crush4", 32'h7FF0_0000, 32'h8000_0000);
    crush_bits = 5'd20;
    offer_pair(16'hFFFF, 16'hFFFF);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("crush20", 32'h0000_0000, 32'h0000_0000);
    crush_bits = 5'd0;
    check_eq("no_underrun_yet", urun_cnt, 32'd0);

    // Frame hold: each pair lasts rate_div+1 = 3 frames
    rate_div = 4'd2;
    offer_pair(16'h1111, 16'h2222);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("hold_a", 32'hFFFF_0000, 32'hFFFF_0000);
    check_eq("hold_a_ready", {31'd0, din_ready}, 32'd0);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("hold_b", 32'hFFFF_0000, 32'hFFFF_0000);
    check_eq("hold_b_ready", {31'd0, din_ready}, 32'd0);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("hold_c", 32'h1111_0000, 32'h2222_0000);
    check_eq("hold_c_ready", {31'd0, din_ready}, 32'd1);
    offer_pair(16'h3333, 16'h4444);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("hold_d", 32'h1111_0000, 32'h2222_0000);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("hold_e", 32'h1111_0000, 32'h2222_0000);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("hold_f", 32'h3333_0000, 32'h4444_0000);
    check_eq("hold_no_underrun", urun_cnt, 32'd0);

    // Underrun: nothing pending at due frames, last pair repeats
    rate_div = 4'd0;
    run_frame(1'b0, 16'h0, 16'h0);
    exp_urun++;
    check_frame("urun_g", 32'h3333_0000, 32'h4444_0000);
    check_eq("urun_g_cnt", urun_cnt, exp_urun);
    run_frame(1'b0, 16'h0, 16'h0);
    exp_urun++;
    check_eq("urun_h_cnt", urun_cnt, exp_urun);
    // Pair offered in the very cycle of the due slot start: no bypass
    run_frame(1'b1, 16'h5555, 16'h6666);
    exp_urun++;
    check_frame("urun_i", 32'h3333_0000, 32'h4444_0000);
    check_eq("urun_i_cnt", urun_cnt, exp_urun);
    check_eq("urun_i_ready", {31'd0, din_ready}, 32'd0);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("urun_j", 32'h5555_0000, 32'h6666_0000);
    check_eq("urun_j_cnt", urun_cnt, exp_urun);

    // Reset in the middle of a left slot
    offer_pair(16'hFFFF, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      do_fall(1'b1, 1'b0, 16'h0, 16'h0, tb_b, tb_bi);
    end
    exp_strb++;
    check_eq("pre_rst_bit", {31'd0, tb_b}, 32'd1);
    ar = 1'b1;
    @(negedge clk_50);
    check_eq("mid_rst_dacdat", {31'd0, dacdat}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, din_ready}, 32'd0);
    @(negedge clk_50);
    ar = 1'b0;
    offer_pair(16'hABCD, 16'h1234);
    acc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_fall(1'b1, 1'b0, 16'h0, 16'h0, tb_b, tb_bi);
      acc = acc | tb_b;
    end
    for (int k = 0; k < 32; k++) begin
      do_fall(1'b0, 1'b0, 16'h0, 16'h0, tb_b, tb_bi);
      acc = acc | tb_b;
    end
    check_eq("resync_silent", {31'd0, acc}, 32'd0);
    check_eq("resync_no_strb", strb_cnt, exp_strb);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("resync", 32'hABCD_0000, 32'h1234_0000);

    // Disabled: silence, nothing consumed, hold counter frozen
    enable   = 1'b0;
    rate_div = 4'd1;
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("dis_1", 32'h0000_0000, 32'h0000_0000);
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("dis_2", 32'h0000_0000, 32'h0000_0000);
    check_eq("dis_ready", {31'd0, din_ready}, 32'd1);
    check_eq("dis_no_underrun", urun_cnt, exp_urun);
    enable = 1'b1;
    run_frame(1'b0, 16'h0, 16'h0);
    check_frame("en_1", 32'hABCD_0000, 32'h1234_0000);
    check_eq("en_1_no_underrun", urun_cnt, exp_urun);
    run_frame(1'b0, 16'h0, 16'h0);
    exp_urun++;
    check_frame("en_2", 32'hABCD_0000, 32'h1234_0000);
    check_eq("en_2_underrun", urun_cnt, exp_urun);

    repeat (4) @(negedge clk_50);
    check_eq("strb_total", strb_cnt, exp_strb);
    check_eq("strb_total_i2s", strb_cnt_i2s, exp_strb);
    check_eq("urun_total_i2s", urun_cnt_i2s, exp_urun);
    check_eq("ready_i2s", {31'd0, din_ready_i2s}, {31'd0, din_ready});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
